capture_buffer_writer: RTL and testbench

// - Write-side initiator for the capture buffer: accepts a stream of I/Q samples and fills

---
 rtl/capture_buffer_writer_pkg.sv | 24 ++
 rtl/capture_buffer_writer.sv | 129 ++++++++++++
 tb/tb_capture_buffer_writer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/capture_buffer_writer_pkg.sv
// capture_buffer_writer_pkg: FSM states, write-response codes and the I/Q word packing shared
// with the capture buffer read side.
package capture_buffer_writer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SAMPLE,
        S_WRITE,
        S_RESP,
        S_DONE
    } state_e;

    localparam logic BRESP_OKAY = 1'b0;
    localparam logic BRESP_ERR  = 1'b1;
    localparam int   DATA_W     = 32;

    // i lands at [ib+qb-1:qb], q at [qb-1:0], everything above is zero (no sign extension)
    function automatic logic [DATA_W-1:0] pack_iq(input logic [DATA_W-1:0] i,
                                                  input logic [DATA_W-1:0] q,
                                                  input int ib, input int qb);
        return ((i & ((32'd1 << ib) - 32'd1)) << qb) | (q & ((32'd1 << qb) - 32'd1));
    endfunction

endpackage

// File: rtl/capture_buffer_writer.sv
// capture_buffer_writer: accepts I/Q samples, packs each into one word and writes it to
// buffer addresses 0..buffer_length-1, one outstanding write at a time.
module capture_buffer_writer
    import capture_buffer_writer_pkg::*;
#(
    parameter int buffer_length             = 10,
    parameter int index_bits                = 4,
    parameter int i_bits                    = 12,
    parameter int q_bits                    = 12,
    parameter int C_INTERCONNECT_DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [i_bits-1:0]     i_in,
    input  logic [q_bits-1:0]     q_in,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [index_bits-1:0] m_axi_waddr,
    output logic                  m_axi_wvalid,
    input  logic                  s_axi_wready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    input  logic                  s_axi_bresp,
    input  logic                  s_axi_bvalid,
    output logic                  m_axi_bready,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    if (buffer_length > 2 ** index_bits || i_bits + q_bits > DATA_W
        || C_INTERCONNECT_DATA_WIDTH != DATA_W) begin : g_bad_params
        $error("capture_buffer_writer: illegal parameter combination");
    end

    state_e                state_q, state_d;
    logic [index_bits-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  error_q, error_d;
    logic                  abort_q, abort_d;
    logic                  s_ready_q, wvalid_q, bready_q, busy_q, done_q;
    logic                  last;

    assign last = addr_q == index_bits'(buffer_length - 1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        error_d = error_q;
        abort_d = abort_q;
        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (start) begin
                    addr_d  = '0;
                    error_d = 1'b0;
                    state_d = S_WAIT_SAMPLE;
                end
            end
            S_WAIT_SAMPLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (s_valid) begin
                    wdata_d = pack_iq(DATA_W'(i_in), DATA_W'(q_in), i_bits, q_bits);
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // a late abort only takes effect once the outstanding response is collected
                abort_d = abort_q | abort;
                if (s_axi_wready) state_d = S_RESP;
            end
            S_RESP: begin
                abort_d = abort_q | abort;
                if (s_axi_bvalid) begin
                    error_d = error_q | (s_axi_bresp == BRESP_ERR);
                    if (abort_q | abort) begin
                        state_d = S_IDLE;
                    end else if (last) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + index_bits'(1);
                        state_d = S_WAIT_SAMPLE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            error_q   <= 1'b0;
            abort_q   <= 1'b0;
            s_ready_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            error_q   <= error_d;
            abort_q   <= abort_d;
            s_ready_q <= state_d == S_WAIT_SAMPLE;
            wvalid_q  <= state_d == S_WRITE;
            bready_q  <= state_d == S_RESP;
            busy_q    <= state_d != S_IDLE;
            done_q    <= state_d == S_DONE;
        end
    end

    assign s_ready      = s_ready_q;
    assign m_axi_waddr  = addr_q;
    assign m_axi_wvalid = wvalid_q;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_bready = bready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_capture_buffer_writer.sv
// tb_capture_buffer_writer: drives sample captures against a behavioural capture-buffer responder
// and compares every write, pulse and flag with values derived from the packing rule.
module tb_capture_buffer_writer;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, s_valid = 1'b0;
    logic [11:0] i_in = '0, q_in = '0;
    logic        s_axi_wready = 1'b0, s_axi_bresp = 1'b0, s_axi_bvalid = 1'b0;
    logic        s_ready, m_axi_wvalid, m_axi_bready, busy, done, error;
    logic [3:0]  m_axi_waddr;
    logic [31:0] m_axi_wdata;

    capture_buffer_writer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .i_in(i_in), .q_in(q_in), .s_valid(s_valid), .s_ready(s_ready),
        .m_axi_waddr(m_axi_waddr), .m_axi_wvalid(m_axi_wvalid), .s_axi_wready(s_axi_wready),
        .m_axi_wdata(m_axi_wdata), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .m_axi_bready(m_axi_bready), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0;
    int si_q[$], sq_q[$], exp_data[$];
    int log_addr[$], log_data[$], bhs_cyc[$];
    int done_cnt, done_cyc, err_rise_cyc, busy_fall_cyc, stall_obs, stable_viol, sready_bad, bready_viol;
    int stall_addr = -1, stall_left = 0, resp_delay = 0, rd_cnt = 0;
    bit rnd_mode = 0;
    logic [15:0] err_set = '0;
    bit whs = 0, bhs = 0, pend = 0;
    int cur_addr = 0;
    logic prev_wvalid = 0, prev_bready = 0, prev_error = 0, prev_busy = 0;
    logic [3:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    function automatic int pack(int i, int q);
        return (((i % 4096) + 4096) % 4096) * 4096 + (((q % 4096) + 4096) % 4096);
    endfunction

    // capture-buffer responder, sample source and event monitor; decisions at negedge take effect at the next posedge
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            s_axi_wready = 0; s_axi_bvalid = 0; s_axi_bresp = 0; s_valid = 0;
            whs = 0; bhs = 0; pend = 0;
            prev_wvalid = 0; prev_bready = 0; prev_error = 0; prev_busy = 0;
        end else begin
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (error && !prev_error) err_rise_cyc = cyc;
            if (!busy && prev_busy) busy_fall_cyc = cyc;
            if (prev_wvalid && !whs && (!m_axi_wvalid || m_axi_waddr != prev_addr || m_axi_wdata != prev_data))
                stable_viol++;
            if (prev_bready && !bhs && !m_axi_bready) bready_viol++;
            if (m_axi_wvalid && s_ready) sready_bad++;
            prev_wvalid = m_axi_wvalid; prev_bready = m_axi_bready; prev_error = error; prev_busy = busy;
            prev_addr = m_axi_waddr; prev_data = m_axi_wdata;
            if (whs) begin pend = 1; rd_cnt = resp_delay; end
            if (bhs) begin s_axi_bvalid = 0; pend = 0; end
            whs = 0; bhs = 0;
            if (m_axi_wvalid && stall_left > 0 && int'(m_axi_waddr) == stall_addr) begin
                s_axi_wready = 0; stall_left--; stall_obs++;
            end else begin
                s_axi_wready = m_axi_wvalid && (!rnd_mode || $urandom_range(0, 2) != 0);
            end
            if (s_axi_wready && m_axi_wvalid) begin
                whs = 1; cur_addr = int'(m_axi_waddr);
                log_addr.push_back(int'(m_axi_waddr)); log_data.push_back(int'(m_axi_wdata));
            end
            if (pend && !s_axi_bvalid) begin
                if (rd_cnt > 0) rd_cnt--;
                else begin s_axi_bvalid = 1; s_axi_bresp = err_set[cur_addr]; end
            end
            if (s_axi_bvalid && m_axi_bready) begin bhs = 1; bhs_cyc.push_back(cyc); end
            s_valid = si_q.size() > 0;
            if (s_valid) begin i_in = 12'(si_q[0]); q_in = 12'(sq_q[0]); end
            if (s_valid && s_ready) begin void'(si_q.pop_front()); void'(sq_q.pop_front()); end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_env();
        si_q.delete(); sq_q.delete(); exp_data.delete();
        log_addr.delete(); log_data.delete(); bhs_cyc.delete();
        done_cnt = 0; done_cyc = -1; err_rise_cyc = -1; busy_fall_cyc = -1;
        stall_obs = 0; stable_viol = 0; sready_bad = 0; bready_viol = 0;
        stall_addr = -1; stall_left = 0; resp_delay = 0; rnd_mode = 0; err_set = '0;
    endtask

    task automatic load(bit rnd);
        int i, q;
        for (int k = 0; k < 10; k++) begin
            i = rnd ? int'($urandom_range(0, 4095)) - 2048 : k;
            q = rnd ? int'($urandom_range(0, 4095)) - 2048 : -k;
            si_q.push_back(i); sq_q.push_back(q); exp_data.push_back(pack(i, q));
        end
    endtask

    task automatic start_capture();
        tick(); start = 1;
        tick(); start = 0;
    endtask

    task automatic wait_idle(output bit to);
        int n = 0;
        while (busy && n < 400) begin tick(); n++; end
        to = busy;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) tick();
        checks++; if (busy !== 0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (m_axi_wvalid !== 0 || m_axi_bready !== 0 || s_ready !== 0) begin
            errors++; $display("FAIL reset_hs got wvalid=%b bready=%b s_ready=%b want 0", m_axi_wvalid, m_axi_bready, s_ready);
        end
        checks++; if (done !== 0 || error !== 0) begin errors++; $display("FAIL reset_flags got done=%b error=%b want 0", done, error); end
        checks++; if (m_axi_waddr !== 0 || m_axi_wdata !== 0) begin
            errors++; $display("FAIL reset_addr_data got addr=%0d data=%h want 0", m_axi_waddr, m_axi_wdata);
        end
        rst_n = 1;
        tick();
    endtask

    task automatic test_full_capture(bit rnd, string name);
        bit to;
        load(rnd);
        start_capture();
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL %s_timeout busy stuck", name); end
        checks++; if (log_addr.size() != 10) begin errors++; $display("FAIL %s_count got=%0d want=10", name, log_addr.size()); end
        for (int k = 0; k < log_addr.size() && k < 10; k++) begin
            checks++; if (log_addr[k] != k || log_data[k] != exp_data[k]) begin
                errors++; $display("FAIL %s_write%0d got addr=%0d data=%h want addr=%0d data=%h",
                                   name, k, log_addr[k], log_data[k], k, exp_data[k]);
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s_done_count got=%0d want=1", name, done_cnt); end
        checks++; if (bhs_cyc.size() != 10 || done_cyc != bhs_cyc[bhs_cyc.size()-1] + 1) begin
            errors++; $display("FAIL %s_done_timing got=%0d resp=%0d", name, done_cyc, bhs_cyc.size());
        end
        checks++; if (error !== (|err_set[9:0])) begin errors++; $display("FAIL %s_error got=%b want=%b", name, error, |err_set[9:0]); end
        checks++; if (stable_viol != 0 || sready_bad != 0 || bready_viol != 0) begin
            errors++; $display("FAIL %s_protocol got stable=%0d sready=%0d bready=%0d want 0", name, stable_viol, sready_bad, bready_viol);
        end
    endtask

    task automatic test_backpressure();
        clear_env(); stall_addr = 3; stall_left = 5;
        test_full_capture(0, "backpressure");
        checks++; if (stall_obs != 5) begin errors++; $display("FAIL bp_stall_cycles got=%0d want=5", stall_obs); end
    endtask

    task automatic test_error_response();
        clear_env(); err_set[7] = 1;
        test_full_capture(0, "errresp");
        checks++; if (bhs_cyc.size() < 8 || err_rise_cyc != bhs_cyc[7] + 1) begin
            errors++; $display("FAIL err_rise got=%0d want resp7+1", err_rise_cyc);
        end
        repeat (2) tick();
        checks++; if (error !== 1) begin errors++; $display("FAIL err_sticky got=%b want=1", error); end
        clear_env(); load(0);
        start_capture();
        checks++; if (error !== 0) begin errors++; $display("FAIL err_clear_on_start got=%b want=0", error); end
        begin bit to; wait_idle(to); end
    endtask

    task automatic test_abort();
        bit to;
        int n = 0;
        clear_env(); resp_delay = 4; load(0);
        start_capture();
        while (!(m_axi_bready && m_axi_waddr == 4) && n < 200) begin tick(); n++; end
        checks++; if (n >= 200) begin errors++; $display("FAIL abort_reach_resp4 timeout"); end
        abort = 1; tick(); abort = 0;
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL abort_timeout busy stuck"); end
        checks++; if (log_addr.size() != 5 || bhs_cyc.size() != 5) begin
            errors++; $display("FAIL abort_writes got w=%0d r=%0d want 5/5", log_addr.size(), bhs_cyc.size());
        end
        checks++; if (bhs_cyc.size() == 0 || busy_fall_cyc != bhs_cyc[bhs_cyc.size()-1] + 1 || bready_viol != 0) begin
            errors++; $display("FAIL abort_idle_after_resp got fall=%0d bready_viol=%0d", busy_fall_cyc, bready_viol);
        end
        repeat (3) tick();
        checks++; if (done_cnt != 0 || busy !== 0) begin errors++; $display("FAIL abort_no_done got done=%0d busy=%b want 0", done_cnt, busy); end
        clear_env();
        test_full_capture(0, "after_abort");
    endtask

    task automatic test_reset_mid_write();
        int n = 0;
        clear_env(); err_set[1] = 1; stall_addr = 2; stall_left = 1000; load(0);
        start_capture();
        while (!(m_axi_wvalid && m_axi_waddr == 2) && n < 200) begin tick(); n++; end
        checks++; if (n >= 200 || error !== 1) begin errors++; $display("FAIL rstmid_pre got error=%b want=1", error); end
        rst_n = 0; tick();
        checks++; if (m_axi_wvalid !== 0 || busy !== 0 || done !== 0 || error !== 0 || m_axi_bready !== 0) begin
            errors++; $display("FAIL rstmid_outputs got wvalid=%b busy=%b done=%b error=%b bready=%b want 0",
                               m_axi_wvalid, busy, done, error, m_axi_bready);
        end
        rst_n = 1; clear_env(); tick();
    endtask

    task automatic test_start_while_busy();
        bit to;
        int n = 0;
        clear_env(); load(0);
        start_capture();
        while (busy && n < 400) begin
            start = (m_axi_waddr < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick(); n++;
        end
        start = 0;
        to = busy;
        checks++; if (to) begin errors++; $display("FAIL swb_timeout busy stuck"); end
        checks++; if (log_addr.size() != 10 || done_cnt != 1) begin
            errors++; $display("FAIL swb_count got writes=%0d done=%0d want 10/1", log_addr.size(), done_cnt);
        end
        for (int k = 0; k < log_addr.size() && k < 10; k++) begin
            checks++; if (log_addr[k] != k) begin errors++; $display("FAIL swb_addr%0d got=%0d want=%0d", k, log_addr[k], k); end
        end
        checks++; if (bhs_cyc.size() != 10 || done_cyc != bhs_cyc[9] + 1) begin
            errors++; $display("FAIL swb_done_timing got=%0d", done_cyc);
        end
        repeat (3) tick();
        checks++; if (busy !== 0) begin errors++; $display("FAIL swb_no_restart got busy=%b want=0", busy); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            clear_env();
            rnd_mode = 1; resp_delay = $urandom_range(0, 3); err_set = 16'($urandom_range(0, 1023));
            test_full_capture(1, "random");
        end
    endtask

    initial begin
        clear_env();
        test_reset();
        clear_env();
        test_full_capture(0, "full");
        test_backpressure();
        test_error_response();
        test_abort();
        test_reset_mid_write();
        test_start_while_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
